// File: rtl/muldiv_pkg.sv
// muldiv_pkg: funct codes, FSM states and sizing helper shared by the
// iterative multiply/divide unit and its bench.
`timescale 1ns/1ps
package muldiv_pkg;

   // MIPS R-type funct codes handled by the unit
   localparam logic [5:0] FUNCT_MFHI  = 6'h10;
   localparam logic [5:0] FUNCT_MTHI  = 6'h11;
   localparam logic [5:0] FUNCT_MFLO  = 6'h12;
   localparam logic [5:0] FUNCT_MTLO  = 6'h13;
   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_DIV   = 6'h1A;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } muldiv_state_e;

   // Bits needed for an iteration counter running 0..w-1
   function automatic int muldiv_cnt_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider with
// HI/LO registers. One WIDTH-iteration CALC phase, then a FIX cycle for
// sign correction; HI/LO are written only when FIX hands over to DONE.
`timescale 1ns/1ps
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
)(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [5:0]       funct_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_zero_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] result_o
);

   localparam int CW = muldiv_cnt_width(WIDTH);
   localparam int AW = 2*WIDTH + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH-1);

   muldiv_state_e    state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [AW-1:0]    acc_q, acc_d;        // shared shift register
   logic [WIDTH-1:0] opnd_q, opnd_d;      // |multiplicand| or |divisor|
   logic [WIDTH-1:0] dividend_q, dividend_d; // raw src1 for divide-by-zero HI
   logic             is_div_q, is_div_d;
   logic             neg_lo_q, neg_lo_d;  // negate product / quotient
   logic             neg_hi_q, neg_hi_d;  // negate remainder
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic             accept;
   logic             is_mul_op, is_div_op, is_signed_op;
   logic             src1_neg, src2_neg;
   logic [WIDTH-1:0] src1_abs, src2_abs;
   logic [AW-1:0]    step_acc;
   logic [WIDTH-1:0] fix_hi, fix_lo;

   // Request decode: operand magnitudes and signs for the incoming op
   always_comb begin
      accept       = start_i && !flush_i && (state_q == ST_IDLE || state_q == ST_DONE);
      is_mul_op    = (funct_i == FUNCT_MULT) || (funct_i == FUNCT_MULTU);
      is_div_op    = (funct_i == FUNCT_DIV)  || (funct_i == FUNCT_DIVU);
      is_signed_op = (funct_i == FUNCT_MULT) || (funct_i == FUNCT_DIV);
      src1_neg     = is_signed_op && src1_i[WIDTH-1];
      src2_neg     = is_signed_op && src2_i[WIDTH-1];
      src1_abs     = src1_neg ? -src1_i : src1_i;
      src2_abs     = src2_neg ? -src2_i : src2_i;
   end

   // One iteration of either algorithm on the shared shift register
   always_comb begin
      logic [WIDTH:0] sum;
      logic [AW-1:0]  shifted;
      logic [WIDTH:0] trial;
      sum      = '0;
      shifted  = '0;
      trial    = '0;
      step_acc = acc_q;
      if (is_div_q) begin
         // restoring divide: remainder in the upper half, quotient bits shift in at the bottom
         shifted = {acc_q[AW-2:0], 1'b0};
         trial   = shifted[AW-1:WIDTH] - {1'b0, opnd_q};
         if (shifted[AW-1:WIDTH] >= {1'b0, opnd_q}) begin
            step_acc = {trial, shifted[WIDTH-1:1], 1'b1};
         end else begin
            step_acc = shifted;
         end
      end else begin
         // shift-add multiply: accumulate into the upper half, consume multiplier LSB
         sum      = acc_q[AW-1:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
         step_acc = {1'b0, sum, acc_q[WIDTH-1:1]};
      end
   end

   // Sign correction and special-case results applied in FIX
   always_comb begin
      logic [2*WIDTH-1:0] prod;
      logic [WIDTH-1:0]   quot, rem;
      prod = neg_lo_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
      quot = acc_q[WIDTH-1:0];
      rem  = acc_q[2*WIDTH-1:WIDTH];
      if (is_div_q) begin
         if (dz_q) begin
            fix_lo = '1;
            fix_hi = dividend_q;
         end else begin
            fix_lo = neg_lo_q ? -quot : quot;
            fix_hi = neg_hi_q ? -rem  : rem;
         end
      end else begin
         fix_lo = prod[WIDTH-1:0];
         fix_hi = prod[2*WIDTH-1:WIDTH];
      end
   end

   // FSM next state plus operand latching and HI/LO updates
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opnd_d     = opnd_q;
      dividend_d = dividend_q;
      is_div_d   = is_div_q;
      neg_lo_d   = neg_lo_q;
      neg_hi_d   = neg_hi_q;
      dz_d       = dz_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (accept) begin
               if (is_mul_op || is_div_op) begin
                  state_d    = ST_CALC;
                  cnt_d      = '0;
                  is_div_d   = is_div_op;
                  opnd_d     = is_div_op ? src2_abs : src1_abs;
                  acc_d      = {1'b0, {WIDTH{1'b0}}, (is_div_op ? src1_abs : src2_abs)};
                  neg_lo_d   = src1_neg ^ src2_neg;
                  neg_hi_d   = is_div_op && src1_neg;
                  dz_d       = is_div_op && (src2_i == '0);
                  dividend_d = src1_i;
               end else if (funct_i == FUNCT_MTHI) begin
                  hi_d = src1_i;
               end else if (funct_i == FUNCT_MTLO) begin
                  lo_d = src1_i;
               end
            end
         end
         ST_CALC: begin
            if (flush_i) begin
               state_d = ST_IDLE;
            end else begin
               acc_d = step_acc;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_FIX;
               end
            end
         end
         ST_FIX: begin
            if (flush_i) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
               hi_d    = fix_hi;
               lo_d    = fix_lo;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers with asynchronous active-low clear
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         opnd_q     <= '0;
         dividend_q <= '0;
         is_div_q   <= 1'b0;
         neg_lo_q   <= 1'b0;
         neg_hi_q   <= 1'b0;
         dz_q       <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opnd_q     <= opnd_d;
         dividend_q <= dividend_d;
         is_div_q   <= is_div_d;
         neg_lo_q   <= neg_lo_d;
         neg_hi_q   <= neg_hi_d;
         dz_q       <= dz_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   // Status outputs and the zero-latency mfhi/mflo read port
   always_comb begin
      busy_o     = (state_q == ST_CALC) || (state_q == ST_FIX);
      done_o     = (state_q == ST_DONE);
      div_zero_o = (state_q == ST_DONE) && dz_q;
      hi_o       = hi_q;
      lo_o       = lo_q;
      if (funct_i == FUNCT_MFHI) begin
         result_o = hi_q;
      end else if (funct_i == FUNCT_MFLO) begin
         result_o = lo_q;
      end else begin
         result_o = '0;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit (WIDTH=32
// and WIDTH=8) against an arithmetic reference model.
`timescale 1ns/1ps
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start, flush;
   logic [5:0]  funct;
   logic [31:0] src1, src2;
   logic        busy, done, dz;
   logic [31:0] hi, lo, res;

   logic        start8, flush8;
   logic [5:0]  funct8;
   logic [7:0]  a8, b8;
   logic        busy8, done8, dz8;
   logic [7:0]  hi8, lo8, res8;

   int total = 0;
   int bad   = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk_i(clk), .rst_i(rst_n), .start_i(start), .funct_i(funct),
      .src1_i(src1), .src2_i(src2), .flush_i(flush),
      .busy_o(busy), .done_o(done), .div_zero_o(dz),
      .hi_o(hi), .lo_o(lo), .result_o(res)
   );

   muldiv_unit #(.WIDTH(8)) dut8 (
      .clk_i(clk), .rst_i(rst_n), .start_i(start8), .funct_i(funct8),
      .src1_i(a8), .src2_i(b8), .flush_i(flush8),
      .busy_o(busy8), .done_o(done8), .div_zero_o(dz8),
      .hi_o(hi8), .lo_o(lo8), .result_o(res8)
   );

   // Reference: MIPS HI/LO semantics from plain 64-bit arithmetic
   task automatic model32(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] mh, output logic [31:0] ml, output logic mz);
      longint sa, sb, q, r;
      logic [63:0] p;
      mz = 1'b0; mh = '0; ml = '0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (f)
         FUNCT_MULT:  begin p = sa * sb; mh = p[63:32]; ml = p[31:0]; end
         FUNCT_MULTU: begin p = {32'b0, a} * {32'b0, b}; mh = p[63:32]; ml = p[31:0]; end
         FUNCT_DIV, FUNCT_DIVU: begin
            if (b == 32'd0) begin
               ml = '1; mh = a; mz = 1'b1;
            end else if (f == FUNCT_DIV) begin
               q = sa / sb; r = sa % sb;
               ml = q[31:0]; mh = r[31:0];
            end else begin
               ml = a / b; mh = a % b;
            end
         end
         default: ;
      endcase
   endtask

   task automatic model8(input logic [5:0] f, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] mh, output logic [7:0] ml, output logic mz);
      int sa, sb, q, r;
      logic [15:0] p;
      mz = 1'b0; mh = '0; ml = '0;
      sa = int'($signed(a));
      sb = int'($signed(b));
      case (f)
         FUNCT_MULT:  begin q = sa * sb; p = q[15:0]; mh = p[15:8]; ml = p[7:0]; end
         FUNCT_MULTU: begin p = {8'b0, a} * {8'b0, b}; mh = p[15:8]; ml = p[7:0]; end
         FUNCT_DIV, FUNCT_DIVU: begin
            if (b == 8'd0) begin
               ml = '1; mh = a; mz = 1'b1;
            end else if (f == FUNCT_DIV) begin
               q = sa / sb; r = sa % sb;
               ml = q[7:0]; mh = r[7:0];
            end else begin
               ml = a / b; mh = a % b;
            end
         end
         default: ;
      endcase
   endtask

   // Present a request at the current negedge; return at the next negedge
   task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; funct = f; src1 = a; src2 = b;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; funct = 6'h00;
   endtask

   // Count busy cycles until done_o, bounded
   task automatic wait_done(output int nbusy, output bit tmo);
      nbusy = 0;
      for (int g = 0; g < 200 && done !== 1'b1; g++) begin
         if (busy === 1'b1) nbusy++;
         @(negedge clk);
      end
      tmo = (done !== 1'b1);
   endtask

   task automatic test_reset();
      total++;
      if ({busy, done, dz} !== 3'b000) begin
         bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, dz});
      end
      total++;
      if (hi !== 32'd0 || lo !== 32'd0) begin
         bad++; $display("FAIL reset_hilo got=%h/%h want=0/0", hi, lo);
      end
      funct = FUNCT_MFHI; #1;
      total++;
      if (res !== 32'd0) begin
         bad++; $display("FAIL reset_result got=%h want=0", res);
      end
      funct = 6'h00;
   endtask

   task automatic test_multu_max();
      int nb; bit tmo;
      issue(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(nb, tmo);
      total++;
      if (tmo || nb != 33) begin
         bad++; $display("FAIL multu_busy got=%0d tmo=%0d want=33", nb, tmo);
      end
      total++;
      if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001 || dz !== 1'b0) begin
         bad++; $display("FAIL multu_max got=%h/%h dz=%b want=fffffffe/00000001 dz=0", hi, lo, dz);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL done_pulse got done=%b busy=%b want=0/0", done, busy);
      end
   endtask

   task automatic test_back_to_back();
      int nb; bit tmo;
      issue(FUNCT_MULT, -32'sd7, 32'sd3);
      wait_done(nb, tmo);
      total++;
      if (tmo || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
         bad++; $display("FAIL mult_neg got=%h/%h tmo=%0d want=ffffffff/ffffffeb", hi, lo, tmo);
      end
      // next request in the DONE cycle itself
      issue(FUNCT_DIV, -32'sd7, 32'sd2);
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         bad++; $display("FAIL b2b_nogap got busy=%b done=%b want=1/0", busy, done);
      end
      wait_done(nb, tmo);
      total++;
      if (tmo || nb != 33 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
         bad++; $display("FAIL div_neg got=%h/%h busy=%0d want=ffffffff/fffffffd busy=33", hi, lo, nb);
      end
   endtask

   task automatic test_div_special();
      int nb; bit tmo;
      issue(FUNCT_DIVU, 32'd100, 32'd0);
      wait_done(nb, tmo);
      total++;
      if (tmo || lo !== 32'hFFFF_FFFF || hi !== 32'd100 || dz !== 1'b1) begin
         bad++; $display("FAIL divu_zero got=%h/%h dz=%b want=00000064/ffffffff dz=1", hi, lo, dz);
      end
      issue(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(nb, tmo);
      total++;
      if (tmo || lo !== 32'h8000_0000 || hi !== 32'd0 || dz !== 1'b0) begin
         bad++; $display("FAIL div_ovf got=%h/%h dz=%b want=00000000/80000000 dz=0", hi, lo, dz);
      end
   endtask

   task automatic test_mthi_mtlo();
      int nb; bit tmo;
      logic [31:0] eh, el; logic ez;
      @(negedge clk);
      start = 1'b1; funct = FUNCT_MTHI; src1 = 32'h1234;
      @(posedge clk); @(negedge clk);
      start = 1'b0; funct = FUNCT_MFHI; #1;
      total++;
      if (res !== 32'h1234 || done !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL mthi_mfhi got=%h done=%b busy=%b want=1234/0/0", res, done, busy);
      end
      @(negedge clk);
      start = 1'b1; funct = FUNCT_MTLO; src1 = 32'hBEEF;
      @(posedge clk); @(negedge clk);
      start = 1'b0; funct = FUNCT_MFLO; #1;
      total++;
      if (res !== 32'hBEEF || hi !== 32'h1234) begin
         bad++; $display("FAIL mtlo_mflo got=%h hi=%h want=beef hi=1234", res, hi);
      end
      @(negedge clk);
      issue(FUNCT_MULT, 32'd5, 32'd6);
      start = 1'b1; funct = FUNCT_MTLO; src1 = 32'hDEAD;
      @(posedge clk); @(negedge clk);
      start = 1'b0; funct = FUNCT_MFLO; #1;
      total++;
      if (lo !== 32'hBEEF || res !== 32'hBEEF || busy !== 1'b1) begin
         bad++; $display("FAIL mtlo_busy got lo=%h res=%h busy=%b want=beef/beef/1", lo, res, busy);
      end
      funct = 6'h00;
      wait_done(nb, tmo);
      model32(FUNCT_MULT, 32'd5, 32'd6, eh, el, ez);
      total++;
      if (tmo || hi !== eh || lo !== el) begin
         bad++; $display("FAIL mult_after_mtlo got=%h/%h want=%h/%h", hi, lo, eh, el);
      end
   endtask

   task automatic test_flush();
      int nb; bit tmo; bit saw;
      @(negedge clk);
      start = 1'b1; funct = FUNCT_MTHI; src1 = 32'hAAAA;
      @(posedge clk); @(negedge clk);
      funct = FUNCT_MTLO; src1 = 32'h5555;
      @(posedge clk); @(negedge clk);
      start = 1'b0; funct = 6'h00;
      issue(FUNCT_DIVU, 32'd10, 32'd3);
      repeat (4) @(negedge clk);
      flush = 1'b1;
      @(posedge clk); @(negedge clk);
      flush = 1'b0;
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL flush_calc got busy=%b done=%b want=0/0", busy, done);
      end
      saw = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1) saw = 1'b1;
      end
      total++;
      if (saw || hi !== 32'hAAAA || lo !== 32'h5555) begin
         bad++; $display("FAIL flush_keep got=%h/%h done_seen=%0d want=aaaa/5555 0", hi, lo, saw);
      end
      // flush wins over start in IDLE
      start = 1'b1; flush = 1'b1; funct = FUNCT_MTHI; src1 = 32'h7777;
      @(posedge clk); @(negedge clk);
      start = 1'b0; flush = 1'b0; funct = 6'h00;
      total++;
      if (hi !== 32'hAAAA) begin
         bad++; $display("FAIL flush_idle got=%h want=aaaa", hi);
      end
      // flush in DONE suppresses a same-cycle start
      issue(FUNCT_MULTU, 32'd2, 32'd3);
      wait_done(nb, tmo);
      start = 1'b1; flush = 1'b1; funct = FUNCT_MULTU; src1 = 32'd4; src2 = 32'd5;
      @(posedge clk); @(negedge clk);
      start = 1'b0; flush = 1'b0; funct = 6'h00;
      total++;
      if (tmo || busy !== 1'b0 || lo !== 32'd6 || hi !== 32'd0) begin
         bad++; $display("FAIL flush_done got busy=%b hilo=%h/%h want=0 0/6", busy, hi, lo);
      end
   endtask

   task automatic test_async_reset();
      issue(FUNCT_MULT, 32'd123, 32'd456);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({busy, done, dz} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
         bad++; $display("FAIL async_reset got flags=%b hilo=%h/%h want=000 0/0", {busy, done, dz}, hi, lo);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_random32();
      int nb; bit tmo;
      logic [5:0] f; logic [31:0] a, b, eh, el; logic ez;
      logic [5:0] ops [4];
      ops[0] = FUNCT_MULT; ops[1] = FUNCT_MULTU; ops[2] = FUNCT_DIV; ops[3] = FUNCT_DIVU;
      for (int t = 0; t < 40; t++) begin
         f = ops[$urandom_range(0, 3)];
         a = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 20));
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) a = -32'($urandom_range(0, 1000));
         model32(f, a, b, eh, el, ez);
         issue(f, a, b);
         wait_done(nb, tmo);
         $display("txn %0d f=%h a=%h b=%h hi=%h lo=%h dz=%b", t, f, a, b, hi, lo, dz);
         total++;
         if (tmo || nb != 33 || hi !== eh || lo !== el || dz !== ez) begin
            bad++;
            $display("FAIL rand32 got=%h/%h dz=%b busy=%0d want=%h/%h dz=%b busy=33",
                     hi, lo, dz, nb, eh, el, ez);
         end
      end
   endtask

   task automatic test_width8();
      int nb; bit tmo;
      logic [5:0] f; logic [7:0] a, b, eh, el; logic ez;
      for (int t = 0; t < 21; t++) begin
         if (t == 0) begin
            f = FUNCT_MULTU; a = 8'd200; b = 8'd200;
         end else begin
            f = 6'h18 + 6'($urandom_range(0, 3));
            a = 8'($urandom);
            b = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
            if (t == 1) begin f = FUNCT_DIV; a = 8'h80; b = 8'hFF; end
         end
         model8(f, a, b, eh, el, ez);
         start8 = 1'b1; funct8 = f; a8 = a; b8 = b;
         @(posedge clk); @(negedge clk);
         start8 = 1'b0; funct8 = 6'h00;
         nb = 0;
         for (int g = 0; g < 50 && done8 !== 1'b1; g++) begin
            if (busy8 === 1'b1) nb++;
            @(negedge clk);
         end
         tmo = (done8 !== 1'b1);
         $display("txn8 %0d f=%h a=%h b=%h hi=%h lo=%h dz=%b", t, f, a, b, hi8, lo8, dz8);
         total++;
         if (tmo || nb != 9 || hi8 !== eh || lo8 !== el || dz8 !== ez) begin
            bad++;
            $display("FAIL w8 got=%h/%h dz=%b busy=%0d want=%h/%h dz=%b busy=9",
                     hi8, lo8, dz8, nb, eh, el, ez);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct = 6'h00; src1 = '0; src2 = '0;
      start8 = 1'b0; flush8 = 1'b0; funct8 = 6'h00; a8 = '0; b8 = '0;
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_multu_max();
      test_back_to_back();
      test_div_special();
      test_mthi_mtlo();
      test_flush();
      test_async_reset();
      test_random32();
      test_width8();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with HI/LO registers for the MIPS CPU datapath, extending the ALU control decode path to multi-cycle operations. It decodes the R-type funct field for mult/multu/div/divu/mthi/mtlo/mfhi/mflo and runs a WIDTH-iteration shift-add multiplier or restoring divider. It sits beside the ALU in EX and reports completion through a busy/done handshake that the CPU control uses to stall.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be at least 4.
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  request; sampled with funct_i and the operands.
- funct_i  input  6  MIPS funct field: mult 0x18, multu 0x19, div 0x1A, divu 0x1B, mfhi 0x10, mthi 0x11, mflo 0x12, mtlo 0x13.
- src1_i  input  WIDTH  rs operand (multiplicand or dividend; mthi/mtlo data).
- src2_i  input  WIDTH  rt operand (multiplier or divisor).
- flush_i  input  1  synchronous cancel of an in-flight operation.
- busy_o  output  1  an operation is in progress; reset value 0.
- done_o  output  1  one-cycle completion pulse; reset value 0.
- div_zero_o  output  1  valid with done_o; the divisor was 0; reset value 0.
- hi_o  output  WIDTH  HI register; reset value 0.
- lo_o  output  WIDTH  LO register; reset value 0.
- result_o  output  WIDTH  combinational: hi_o when funct_i is mfhi, lo_o when funct_i is mflo, 0 otherwise.

## Operation
- FSM states:
  - IDLE: accepts requests.
  - CALC: WIDTH iterations, one per cycle; an iteration counter counts 0..WIDTH-1.
  - FIX: sign correction.
  - DONE: drives done_o; accepts requests exactly as IDLE does.
- Request acceptance in IDLE or DONE (start_i=1):
  - mult/multu/div/divu: latch operands and go to CALC.
  - mthi/mtlo: write src1_i into HI or LO at that edge; stay in or return to IDLE; no done_o.
  - Any other funct: ignored.
- Signed ops (mult, div):
  - Latch the absolute values of the operands and record the result signs.
  - Product sign = sign1 XOR sign2.
  - Quotient sign = sign1 XOR sign2; remainder sign = sign1.
  - FIX negates two's-complement modulo 2^WIDTH (2^(2·WIDTH) for the product).
  - Unsigned ops pass through FIX unchanged.
- Multiply: HI:LO = full 2·WIDTH-bit product.
- Divide: LO = quotient, HI = remainder. Result signs follow truncation toward zero.
- Divide by zero (signed or unsigned):
  - LO = all ones, HI = original src1_i.
  - div_zero_o = 1 during the done_o cycle.
- Signed overflow, most-negative / -1: LO = most-negative value, HI = 0; div_zero_o = 0.
- Write timing:
  - HI and LO are written only on the FIX→DONE edge.
  - A flushed operation leaves HI and LO unchanged.
- While busy_o=1:
  - start_i of any funct is ignored, including mthi/mtlo.
  - result_o still reflects the old HI/LO values.
- flush_i:
  - In CALC or FIX: go to IDLE next edge; no done_o.
  - In DONE: suppresses a start_i in the same cycle.
  - In IDLE: no effect; flush_i has priority over start_i.
- Reset mid-operation: all state, HI, LO and outputs clear immediately; FSM goes to IDLE.

## Timing
- Acceptance edge E0 → CALC for cycles 1..WIDTH → FIX in cycle WIDTH+1 → DONE in cycle WIDTH+2.
- busy_o = 1 for exactly WIDTH+1 cycles: CALC and FIX.
- done_o = 1 for exactly one cycle (DONE). New HI/LO values are visible in that same cycle.
- Back-to-back: start_i during DONE begins the next operation. No idle bubble is required.
- mthi/mtlo latency is 1 edge. result_o has zero latency (combinational).

## Structure
- Shared package muldiv_pkg holds:
  - the funct code constants,
  - the state enumeration (IDLE, CALC, FIX, DONE),
  - a helper function computing the counter width as $clog2(WIDTH).
- Single module; no sub-module.
- Datapath: one 2·WIDTH+1-bit shift register used by both algorithms.
  - Multiply: accumulator in the upper half, multiplier in the lower half.
  - Divide: remainder in the upper half, quotient in the lower half.

## Test plan
- multu 0xFFFFFFFF × 0xFFFFFFFF → after 33 busy cycles, done_o=1 with HI=0xFFFFFFFE, LO=0x00000001.
- mult -7 × 3 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then div -7 / 2 issued in the DONE cycle → LO=0xFFFFFFFD, HI=0xFFFFFFFF, with no gap between the two operations.
- divu 100 / 0 → LO=0xFFFFFFFF, HI=100, div_zero_o=1 with done_o. div 0x80000000 / -1 → LO=0x80000000, HI=0, div_zero_o=0.
- mthi 0x1234 with funct_i=mfhi in the next cycle → result_o=0x1234. mtlo while busy → LO unchanged.
- Start divu 10/3, flush_i in cycle 5 → IDLE, no done_o, HI/LO retain their prior values. Async reset asserted mid-CALC → all outputs 0 immediately.
- WIDTH=8: multu 200×200 → HI=0x9C, LO=0x40 after 9 busy cycles.
